riscv_core_mc: RTL and testbench
================================

// Module: riscv_core_mc
// PURPOSE
// Multi-cycle RV32I/RV32E core: successor to the single-cycle core, for instruction/data memories with variable latency.
// Fetch, execute and memory access run in separate FSM states over req/rvalid handshakes; one transaction outstanding per port.
// Parametrised reset vector and register-file size; traps on illegal or misaligned operations and halts.
// Adds ECALL/EBREAK halt and a retire pulse for testbenches.
// PARAMETERS
// RESET_PC  32'h0000_0000  first fetch address after reset; must be 4-byte aligned
// RV32E     0              1: 16 GPRs, register index >15 traps; 0: 32 GPRs
// PORTS
// clk_i          in   1   clock
// rst_ni         in   1   async active-low reset
// imem_req_o     out  1   instruction fetch request
// imem_addr_o    out  32  fetch address (= pc)
// imem_rvalid_i  in   1   fetch data valid
// imem_rdata_i   in   32  instruction word
// dmem_req_o     out  1   data request
// dmem_we_o      out  1   1 = store, 0 = load
// dmem_be_o      out  4   byte enables (shifted by addr[1:0])
// dmem_addr_o    out  32  word address, addr[1:0] forced to 0
// dmem_wdata_o   out  32  store data replicated into lanes (SB x4, SH x2)
// dmem_rvalid_i  in   1   load data valid / store complete
// dmem_rdata_i   in   32  load data
// instr_ret_o    out  1   1-cycle pulse per retired instruction
// halt_o         out  1   sticky: ECALL/EBREAK executed
// trap_o         out  1   sticky: illegal/misaligned; trap_pc_o holds faulting pc
// trap_pc_o      out  32  pc of the trapping instruction
// BEHAVIOUR
// - Reset: state=FETCH, pc=RESET_PC, all GPRs 0, every output 0 except imem_addr_o=RESET_PC. Reset mid-transaction aborts it; memories share the reset and drop pending responses.
// - Handshake: req held high, addr/we/be/wdata stable until the cycle rvalid=1 (may be the same cycle req rises). req drops the cycle after. rvalid with req low is ignored.
// - FSM: FETCH -> EXEC on imem_rvalid_i (instr latched into instr_q).
// - EXEC: ALU/LUI/AUIPC/JAL/JALR/branch/FENCE write back, update pc, pulse instr_ret_o, -> FETCH. Load/store -> MEM.
// - MEM: -> FETCH on dmem_rvalid_i; load data written back, instr_ret_o pulses in that cycle.
// - Any trap or halt -> HALT, terminal until reset: no requests, pc frozen, no register writes.
// - Cycle counts with 0-wait memory: ALU/branch/jump 2 cycles; load/store 3 cycles. Each wait cycle on rvalid adds 1.
// - x0 reads 0; writes to x0 are discarded.
// - Semantics: RV32I (LUI/AUIPC/JAL/JALR/branches/loads/stores/OP/OP-IMM).
//   - SRAI requires funct7=0100000; SLLI/SRLI require funct7=0, otherwise illegal.
//   - Shifts use op2[4:0]. Arithmetic wraps mod 2^32.
//   - BLT/BGE compare signed; BLTU/BGEU compare unsigned.
//   - JAL/JALR write pc+4. JALR target is (rs1+imm) & ~1.
//   - FENCE is a NOP. ECALL/EBREAK -> halt_o.
// - Traps, all reported in EXEC; no register or pc update:
//   - unknown opcode or funct3, or bad funct7 on OP/shift-imm;
//   - taken branch/jump target[1:0] != 0;
//   - LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0] != 0;
//   - RV32E=1 and any used rd/rs1/rs2 > 15.
// - Loads: LB/LBU/LH/LHU select lane by addr[1:0] and sign/zero-extend. dmem_be_o=0 on loads.
// - pc wraps 0xFFFF_FFFC + 4 -> 0x0000_0000 without trap.
// TESTING
// - ADDI x1,x0,5; ADDI x2,x1,-7 (0-wait mem) -> x2=0xFFFF_FFFE; instr_ret_o pulses at cycles 2 and 4 after reset.
// - imem_rvalid_i delayed 3 cycles every fetch -> imem_req_o/addr stable for 4 cycles; each ALU instr retires after 5 cycles.
// - x1=0x100, x2=0x8000_00AB; SB x2,1(x1); LB x3,1(x1); LBU x4,1(x1) -> be=4'b0010, addr=0x100; x3=0xFFFF_FFAB; x4=0x0000_00AB.
// - BLT x5,x6,+8 with x5=-1, x6=1 -> taken; BLTU same operands -> not taken, pc+4.
// - LW x1,2(x0) -> trap_o=1, trap_pc_o=pc of LW, dmem_req_o never rises, x1 unchanged. RV32E=1 with ADD x17,... -> trap_o.
// - Assert rst_ni low while dmem_req_o=1 -> req low immediately; after release fetch restarts at RESET_PC; ECALL -> halt_o=1, no further requests.

Source files
------------

// File: rtl/riscv_core_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : riscv_core_mc_if
// Brief   : Instruction and data memory req/rvalid bus of the multi-cycle core
// Revision: 1.0
// ============================================================================
interface riscv_core_mc_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rvalid_i, imem_rdata_i,
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rvalid_i, imem_rdata_i,
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rvalid_i, dmem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/riscv_core_mc.sv
`default_nettype none
// ============================================================================
// Module  : riscv_core_mc
// Brief   : Multi-cycle RV32I/RV32E core with variable-latency memory ports
// Revision: 1.0
// ============================================================================
module riscv_core_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          RV32E    = 1'b0
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    riscv_core_mc_if.master  bus,
    output logic             instr_ret_o,
    output logic             halt_o,
    output logic             trap_o,
    output logic [31:0]      trap_pc_o
);
    localparam int NREG = RV32E ? 16 : 32;
    localparam int AW   = RV32E ? 4 : 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, trap_pc_q, trap_pc_d;
    logic        halt_q, halt_d, trap_q, trap_d;
    logic [31:0] rf_q [NREG];

    logic        rf_we;
    logic [31:0] rf_wdata;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, mem_addr, target, wb_val, load_val, lshift;
    logic        illegal, misalign, take, wb_en, is_mem, is_store, is_sys_halt;
    logic        use_rd, use_rs1, use_rs2, reg_bad, alt;
    logic [3:0]  be_base;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub_sra,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return sub_sra ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return sub_sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u  = {instr_q[31:12], 12'b0};
    assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    // Out-of-range indices only occur on RV32E and trap before any use of the value.
    assign rs1_v = (rs1 == 5'd0 || (RV32E && rs1[4])) ? 32'b0 : rf_q[rs1[AW-1:0]];
    assign rs2_v = (rs2 == 5'd0 || (RV32E && rs2[4])) ? 32'b0 : rf_q[rs2[AW-1:0]];

    assign is_store = (opcode == OPC_STORE);
    assign mem_addr = rs1_v + (is_store ? imm_s : imm_i);
    assign lshift   = bus.dmem_rdata_i >> {mem_addr[1:0], 3'b000};

    always_comb begin
        illegal     = 1'b0;
        misalign    = 1'b0;
        take        = 1'b0;
        target      = pc_q + 32'd4;
        wb_en       = 1'b0;
        wb_val      = 32'b0;
        is_mem      = 1'b0;
        is_sys_halt = 1'b0;
        use_rd      = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        alt         = 1'b0;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1; wb_en = 1'b1; wb_val = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; wb_en = 1'b1; wb_val = pc_q + imm_u;
            end
            OPC_JAL: begin
                use_rd = 1'b1; wb_en = 1'b1; wb_val = pc_q + 32'd4;
                take = 1'b1; target = pc_q + imm_j;
            end
            OPC_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wb_en = 1'b1; wb_val = pc_q + 32'd4;
                take = 1'b1; target = (rs1_v + imm_i) & ~32'd1;
                illegal = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; target = pc_q + imm_b;
                case (funct3)
                    3'd0:    take = (rs1_v == rs2_v);
                    3'd1:    take = (rs1_v != rs2_v);
                    3'd4:    take = ($signed(rs1_v) <  $signed(rs2_v));
                    3'd5:    take = ($signed(rs1_v) >= $signed(rs2_v));
                    3'd6:    take = (rs1_v <  rs2_v);
                    3'd7:    take = (rs1_v >= rs2_v);
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
                illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
                misalign = (funct3[1:0] == 2'd1 && mem_addr[0]) ||
                           (funct3 == 3'd2 && mem_addr[1:0] != 2'd0);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1;
                illegal  = (funct3 > 3'd2);
                misalign = (funct3 == 3'd1 && mem_addr[0]) ||
                           (funct3 == 3'd2 && mem_addr[1:0] != 2'd0);
            end
            OPC_OPIMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wb_en = 1'b1;
                alt     = (funct3 == 3'd5) && funct7[5];
                illegal = (funct3 == 3'd1 && funct7 != 7'd0) ||
                          (funct3 == 3'd5 && funct7 != 7'd0 && funct7 != 7'h20);
                wb_val  = alu(funct3, alt, rs1_v, imm_i);
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wb_en = 1'b1;
                alt     = funct7[5];
                illegal = !(funct7 == 7'd0 ||
                            (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
                wb_val  = alu(funct3, alt, rs1_v, rs2_v);
            end
            OPC_FENCE: illegal = (funct3 != 3'd0);
            OPC_SYSTEM: begin
                // Only ECALL (imm=0) and EBREAK (imm=1) with all other fields zero.
                if (instr_q[31:21] == 11'd0 && instr_q[19:7] == 13'd0) is_sys_halt = 1'b1;
                else                                                 illegal     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (take && target[1:0] != 2'd0) misalign = 1'b1;
    end

    assign reg_bad = RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));

    always_comb begin
        case (funct3)
            3'd0:    load_val = {{24{lshift[7]}}, lshift[7:0]};
            3'd1:    load_val = {{16{lshift[15]}}, lshift[15:0]};
            3'd4:    load_val = {24'b0, lshift[7:0]};
            3'd5:    load_val = {16'b0, lshift[15:0]};
            default: load_val = bus.dmem_rdata_i;
        endcase
        case (funct3)
            3'd0:    be_base = 4'b0001;
            3'd1:    be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        halt_d      = halt_q;
        trap_d      = trap_q;
        trap_pc_d   = trap_pc_q;
        rf_we       = 1'b0;
        rf_wdata    = wb_val;
        instr_ret_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_rvalid_i) begin
                    instr_d = bus.imem_rdata_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (illegal || misalign || reg_bad) begin
                    trap_d    = 1'b1;
                    trap_pc_d = pc_q;
                    state_d   = S_HALT;
                end else if (is_sys_halt) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    rf_we       = wb_en && (rd != 5'd0);
                    pc_d        = take ? target : pc_q + 32'd4;
                    instr_ret_o = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.dmem_rvalid_i) begin
                    rf_we       = !is_store && (rd != 5'd0);
                    rf_wdata    = load_val;
                    pc_d        = pc_q + 32'd4;
                    instr_ret_o = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'b0;
            halt_q    <= 1'b0;
            trap_q    <= 1'b0;
            trap_pc_q <= 32'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= 32'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            halt_q    <= halt_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            if (rf_we) rf_q[rd[AW-1:0]] <= rf_wdata;
        end
    end

    // The FETCH reset state must not show a request while reset is still held.
    assign bus.imem_req_o   = rst_ni && (state_q == S_FETCH);
    assign bus.imem_addr_o  = pc_q;
    assign bus.dmem_req_o   = (state_q == S_MEM);
    assign bus.dmem_we_o    = (state_q == S_MEM) && is_store;
    assign bus.dmem_be_o    = ((state_q == S_MEM) && is_store) ? (be_base << mem_addr[1:0]) : 4'b0;
    assign bus.dmem_addr_o  = (state_q == S_MEM) ? {mem_addr[31:2], 2'b00} : 32'b0;
    assign bus.dmem_wdata_o = !((state_q == S_MEM) && is_store) ? 32'b0 :
                              (funct3 == 3'd0) ? {4{rs2_v[7:0]}} :
                              (funct3 == 3'd1) ? {2{rs2_v[15:0]}} : rs2_v;

    assign halt_o    = halt_q;
    assign trap_o    = trap_q;
    assign trap_pc_o = trap_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_core_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_core_mc
// Brief   : Directed program vectors and multi-cycle sequences for riscv_core_mc
// Revision: 1.0
// ============================================================================
module tb_riscv_core_mc;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, LOAD = 7'b0000011, JALR = 7'b1100111;
    localparam logic [31:0] ECALL = 32'h0000_0073, NOP = 32'h0000_0013;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_core_mc_if bus();
    riscv_core_mc_if bus_e();
    logic ret, halt, trap, ret_e, halt_e, trap_e;
    logic [31:0] tpc, tpc_e;

    riscv_core_mc #(.RESET_PC(32'h0), .RV32E(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .instr_ret_o(ret), .halt_o(halt), .trap_o(trap), .trap_pc_o(tpc));
    riscv_core_mc #(.RESET_PC(32'h0), .RV32E(1'b1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_e),
        .instr_ret_o(ret_e), .halt_o(halt_e), .trap_o(trap_e), .trap_pc_o(tpc_e));

    // RV32E instance always fetches ADD x17,x0,x0
    assign bus_e.imem_rvalid_i = bus_e.imem_req_o;
    assign bus_e.imem_rdata_i  = 32'h0000_08B3;
    assign bus_e.dmem_rvalid_i = bus_e.dmem_req_o;
    assign bus_e.dmem_rdata_i  = 32'h0;

    logic [31:0] mem [0:1023];
    int iwait = 0, dwait = 0, icnt, dcnt;
    logic ld_en = 1'b0;
    logic [9:0] ld_idx = '0;
    logic [31:0] ld_val = '0;

    assign bus.imem_rvalid_i = bus.imem_req_o && (icnt >= iwait);
    assign bus.imem_rdata_i  = mem[bus.imem_addr_o[11:2]];
    assign bus.dmem_rvalid_i = bus.dmem_req_o && (dcnt >= dwait);
    assign bus.dmem_rdata_i  = mem[bus.dmem_addr_o[11:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 0; dcnt <= 0;
        end else begin
            icnt <= (bus.imem_req_o && !bus.imem_rvalid_i) ? icnt + 1 : 0;
            dcnt <= (bus.dmem_req_o && !bus.dmem_rvalid_i) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (bus.dmem_req_o && bus.dmem_rvalid_i && bus.dmem_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.dmem_be_o[b]) mem[bus.dmem_addr_o[11:2]][8*b +: 8] <= bus.dmem_wdata_o[8*b +: 8];
    end

    // Mid-cycle monitors; cycle 1 is the first cycle after reset release
    int cyc, nret, irun, ilast, stop_req;
    int ret_cyc [0:15];
    logic [31:0] iprev, st_addr, st_wdata;
    logic [3:0]  st_be;
    logic addr_chg, dreq_seen, st_seen, ld_be_nz;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 1; nret <= 0; irun <= 0; ilast <= 0; stop_req <= 0; iprev <= '0;
            addr_chg <= 1'b0; dreq_seen <= 1'b0; st_seen <= 1'b0; ld_be_nz <= 1'b0;
            st_addr <= '0; st_wdata <= '0; st_be <= '0;
        end else begin
            cyc <= cyc + 1;
            if (ret && nret < 16) begin ret_cyc[nret] <= cyc; nret <= nret + 1; end
            if (bus.imem_req_o) begin
                if (irun != 0 && bus.imem_addr_o != iprev) addr_chg <= 1'b1;
                if (bus.imem_rvalid_i) begin ilast <= irun + 1; irun <= 0; end
                else irun <= irun + 1;
                iprev <= bus.imem_addr_o;
            end else irun <= 0;
            if (bus.dmem_req_o) dreq_seen <= 1'b1;
            if (bus.dmem_req_o && !bus.dmem_we_o && bus.dmem_be_o != 4'b0) ld_be_nz <= 1'b1;
            if (bus.dmem_req_o && bus.dmem_rvalid_i && bus.dmem_we_o && !st_seen) begin
                st_seen <= 1'b1; st_addr <= bus.dmem_addr_o; st_wdata <= bus.dmem_wdata_o; st_be <= bus.dmem_be_o;
            end
            if ((halt || trap) && (bus.imem_req_o || bus.dmem_req_o)) stop_req <= stop_req + 1;
        end
    end

    int nchecks = 0, nerr = 0;
    logic [31:0] prog [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] im = imm;
        logic [31:0] a = rs1, f = f3, d = rd;
        return {im[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] g = f7, b = rs2, a = rs1, f = f3, d = rd;
        return {g[6:0], b[4:0], a[4:0], f[2:0], d[4:0], OPR};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im = imm;
        logic [31:0] b = rs2, a = rs1, f = f3;
        return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im = imm;
        logic [31:0] b = rs2, a = rs1, f = f3;
        return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] e_u(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] im = imm;
        logic [31:0] d = rd;
        return {im[19:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        logic [31:0] im = imm;
        logic [31:0] d = rd;
        return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic load_word(input int idx, input logic [31:0] v);
        ld_idx = idx[9:0]; ld_val = v; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic load_prog();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) load_word(i, prog[i]);
        load_word(64, 32'h0);
        load_word(128, SENT);
        load_word(129, SENT);
    endtask

    task automatic release_and_wait(input string name);
        int n = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        while (!(halt || trap) && n < 400) begin @(negedge clk); n++; end
        check({name, "_done"}, {31'b0, halt || trap}, 32'd1);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = ECALL;
    endtask

    typedef struct {
        string       name;
        logic [31:0] i0, i1, i2, i3;
        int          rd;
        logic [31:0] exp;
        bit          trap;
    } vec_t;
    vec_t vt [15];

    task automatic set_vec(input int k, input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input int rd,
                           input logic [31:0] exp, input bit tr);
        vt[k].name = nm; vt[k].i0 = a; vt[k].i1 = b; vt[k].i2 = c; vt[k].i3 = d;
        vt[k].rd = rd; vt[k].exp = exp; vt[k].trap = tr;
    endtask

    initial begin
        set_vec(0,  "addi_neg", e_i(5,0,0,1,OPI), e_i(-7,1,0,2,OPI), NOP, NOP, 2, 32'hFFFF_FFFE, 0);
        set_vec(1,  "lui_addi", e_u(32'h12345,1,LUI), e_i(32'h678,1,0,1,OPI), NOP, NOP, 1, 32'h1234_5678, 0);
        set_vec(2,  "srli", e_i(-1,0,0,1,OPI), e_i(4,1,5,2,OPI), NOP, NOP, 2, 32'h0FFF_FFFF, 0);
        set_vec(3,  "srai", e_i(-16,0,0,1,OPI), e_i(32'h402,1,5,2,OPI), NOP, NOP, 2, 32'hFFFF_FFFC, 0);
        set_vec(4,  "sltu", e_i(3,0,0,1,OPI), e_i(-1,0,0,2,OPI), e_r(0,2,1,3,3), NOP, 3, 32'd1, 0);
        set_vec(5,  "slt", e_i(3,0,0,1,OPI), e_i(-1,0,0,2,OPI), e_r(0,2,1,2,3), NOP, 3, 32'd0, 0);
        set_vec(6,  "sub_wrap", e_i(1,0,0,1,OPI), e_i(31,1,1,2,OPI), e_r(32,2,0,0,3), NOP, 3, 32'h8000_0000, 0);
        set_vec(7,  "auipc", e_u(1,1,AUIPC), NOP, NOP, NOP, 1, 32'h0000_1000, 0);
        set_vec(8,  "jal", e_j(8,1), e_i(99,0,0,1,OPI), NOP, NOP, 1, 32'd4, 0);
        set_vec(9,  "blt_taken", e_i(-1,0,0,5,OPI), e_i(1,0,0,6,OPI), e_b(8,6,5,4), e_i(7,0,0,5,OPI), 5, 32'hFFFF_FFFF, 0);
        set_vec(10, "bltu_not", e_i(-1,0,0,5,OPI), e_i(1,0,0,6,OPI), e_b(8,6,5,6), e_i(7,0,0,5,OPI), 5, 32'd7, 0);
        set_vec(11, "jalr", e_i(13,0,0,1,OPI), e_i(0,1,0,2,JALR), e_i(55,0,0,2,OPI), NOP, 2, 32'd8, 0);
        set_vec(12, "xori", e_i(240,0,0,1,OPI), e_i(255,1,4,2,OPI), NOP, NOP, 2, 32'h0000_000F, 0);
        set_vec(13, "slli_bad_f7", e_i(32'h401,0,1,2,OPI), NOP, NOP, NOP, 2, SENT, 1);
        set_vec(14, "jalr_misalign", e_i(2,0,0,1,OPI), e_i(0,1,0,0,JALR), NOP, NOP, 1, SENT, 1);

        for (int v = 0; v < 15; v++) begin
            clear_prog();
            prog[0] = vt[v].i0; prog[1] = vt[v].i1; prog[2] = vt[v].i2; prog[3] = vt[v].i3;
            prog[4] = e_s(512, vt[v].rd, 0, 2);
            load_prog();
            release_and_wait(vt[v].name);
            if (vt[v].trap) check({vt[v].name, "_trap"}, {31'b0, trap}, 32'd1);
            else            check({vt[v].name, "_halt"}, {31'b0, halt}, 32'd1);
            check(vt[v].name, mem[128], vt[v].exp);
        end

        // Reset state, retire timing with 0-wait memory, halt silence
        clear_prog();
        prog[0] = e_i(5,0,0,1,OPI); prog[1] = e_i(-7,1,0,2,OPI); prog[2] = e_s(512,2,0,2);
        load_prog();
        @(negedge clk);
        check("rst_imem_req", {31'b0, bus.imem_req_o}, 32'd0);
        check("rst_imem_addr", bus.imem_addr_o, 32'h0);
        check("rst_dmem_req", {31'b0, bus.dmem_req_o}, 32'd0);
        check("rst_flags", {28'b0, ret, halt, trap, bus.dmem_we_o}, 32'd0);
        release_and_wait("timing");
        check("ret_count", nret, 32'd3);
        check("ret0_cycle", ret_cyc[0], 32'd2);
        check("ret1_cycle", ret_cyc[1], 32'd4);
        check("ret2_store_cycle", ret_cyc[2], 32'd7);
        repeat (10) @(negedge clk);
        check("halt_sticky", {31'b0, halt}, 32'd1);
        check("halt_no_req", stop_req, 32'd0);

        // Three wait states on every fetch
        iwait = 3;
        clear_prog();
        prog[0] = e_i(5,0,0,1,OPI); prog[1] = e_i(-7,1,0,2,OPI);
        load_prog();
        release_and_wait("iwait3");
        check("iwait_req_len", ilast, 32'd4);
        check("iwait_addr_stable", {31'b0, addr_chg}, 32'd0);
        check("iwait_ret_spacing", ret_cyc[1] - ret_cyc[0], 32'd5);
        iwait = 0;

        // Byte store lane and sign/zero-extending byte loads
        dwait = 2;
        clear_prog();
        prog[0] = e_i(256,0,0,1,OPI); prog[1] = e_u(32'h80000,2,LUI); prog[2] = e_i(171,2,0,2,OPI);
        prog[3] = e_s(1,2,1,0); prog[4] = e_i(1,1,0,3,LOAD); prog[5] = e_i(1,1,4,4,LOAD);
        prog[6] = e_s(512,3,0,2); prog[7] = e_s(516,4,0,2);
        load_prog();
        release_and_wait("sb_lb");
        check("sb_be", {28'b0, st_be}, 32'h2);
        check("sb_addr", st_addr, 32'h100);
        check("sb_wdata", st_wdata, 32'hABAB_ABAB);
        check("sb_mem", mem[64], 32'h0000_AB00);
        check("lb_sext", mem[128], 32'hFFFF_FFAB);
        check("lbu_zext", mem[129], 32'h0000_00AB);
        check("load_be_zero", {31'b0, ld_be_nz}, 32'd0);
        dwait = 0;

        // Misaligned LW traps in EXEC without touching the data port
        clear_prog();
        prog[0] = e_i(9,0,0,1,OPI); prog[1] = e_i(2,0,2,1,LOAD); prog[2] = e_s(512,1,0,2);
        load_prog();
        release_and_wait("lw_mis");
        repeat (5) @(negedge clk);
        check("lw_trap", {30'b0, trap, halt}, 32'd2);
        check("lw_trap_pc", tpc, 32'd4);
        check("lw_no_dreq", {31'b0, dreq_seen}, 32'd0);
        check("lw_no_req_after", stop_req, 32'd0);
        check("lw_mem_untouched", mem[128], SENT);
        check("rv32e_trap", {30'b0, trap_e, halt_e}, 32'd2);
        check("rv32e_trap_pc", tpc_e, 32'd0);

        // Reset asserted while a store waits on the data port
        dwait = 20;
        clear_prog();
        prog[0] = NOP; prog[1] = e_s(512,0,0,2);
        load_prog();
        @(posedge clk); #2 rst_n = 1'b1;
        for (int n = 0; n < 50 && !bus.dmem_req_o; n++) @(negedge clk);
        check("mid_dreq_up", {31'b0, bus.dmem_req_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_dreq", {31'b0, bus.dmem_req_o}, 32'd0);
        check("mid_rst_ireq", {31'b0, bus.imem_req_o}, 32'd0);
        check("mid_rst_addr", bus.imem_addr_o, 32'h0);
        dwait = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("restart_req", {31'b0, bus.imem_req_o}, 32'd1);
        check("restart_addr", bus.imem_addr_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
`default_nettype wire
